// File: rtl/codec_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : codec_pkg
//  Description : Shared constants and types for the CODEC interface.
//                This includes the sample and counter widths, the SCLK phase
//                decodes, the frame event positions and the reset-FSM states.
//  Revision    : 1.0  initial release
// ============================================================================
package codec_pkg;

    localparam int SMPL_W = 16;
    localparam int CNT_W  = 10;

    // Phase within one SCLK period (cnt[4:0]) at which each SCLK edge occurs
    localparam logic [4:0] RISE_PH = 5'd15;
    localparam logic [4:0] FALL_PH = 5'd31;

    // Frame positions; each one names the cnt value of the cycle that ends at the edge
    localparam logic [CNT_W-1:0] LFT_LOAD   = 10'd1023;
    localparam logic [CNT_W-1:0] RHT_LOAD   = 10'd511;
    localparam logic [CNT_W-1:0] LFT_DONE   = 10'd496;
    localparam logic [CNT_W-1:0] FRAME_DONE = 10'd1008;

    typedef enum logic [1:0] {
        INIT = 2'd0,
        WARM = 2'd1,
        RUN  = 2'd2
    } codec_state_t;

endpackage : codec_pkg
`default_nettype wire

// File: rtl/codec_shreg.sv
`default_nettype none
// ============================================================================
//  Module      : codec_shreg
//  Description : Shift register, shifting toward the MSB, with synchronous
//                parallel load. Load has priority over shift.
//  Ports       : clk, rst_n    clock, async active-low reset
//                load          parallel load strobe (priority)
//                load_val      value to load
//                shift_en      shift left by one, ser_in enters at bit 0
//                ser_in        serial input
//                q             register contents
//  Revision    : 1.0  initial release
// ============================================================================
module codec_shreg
    import codec_pkg::*;
#(
    parameter int WIDTH = SMPL_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             shift_en,
    input  logic             ser_in,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (load) begin
            q <= load_val;
        end else if (shift_en) begin
            q <= {q[WIDTH-2:0], ser_in};
        end
    end

endmodule : codec_shreg
`default_nettype wire

// File: rtl/codec_intf.sv
`default_nettype none
// ============================================================================
//  Module      : codec_intf
//  Description : I2S-style CODEC bridge. It generates MCLK, SCLK, LRCLK and
//                the CODEC reset. It deserializes ADC words into left and
//                right samples with a once-per-frame valid pulse, and it
//                serializes the left and right samples to the DAC.
//                The data format is left-justified and MSB first.
//  Options     : CODEC_LOOPBACK_EN - the RX shifter samples the TX shifter
//                MSB instead of SDout, and SDin is held at 0.
//  Ports       : clk, rst_n         50 MHz clock, async active-low reset
//                lft_in, rht_in     samples to transmit
//                SDout              ADC serial data from the CODEC
//                lft_out, rht_out   received samples (update with valid)
//                valid              one-cycle pulse per frame
//                MCLK/SCLK/LRCLK    clk/4, clk/32, clk/1024
//                RSTn               CODEC reset, active low
//                SDin               DAC serial data to the CODEC
//  Revision    : 1.0  initial release
// ============================================================================
module codec_intf
    import codec_pkg::*;
#(
    parameter int INIT_FRAMES = 1,
    parameter int SKIP_FRAMES = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [SMPL_W-1:0] lft_in,
    input  logic [SMPL_W-1:0] rht_in,
    input  logic              SDout,
    output logic [SMPL_W-1:0] lft_out,
    output logic [SMPL_W-1:0] rht_out,
    output logic              valid,
    output logic              MCLK,
    output logic              SCLK,
    output logic              LRCLK,
    output logic              RSTn,
    output logic              SDin
);

    localparam int FRM_MAX = (INIT_FRAMES > SKIP_FRAMES) ? INIT_FRAMES : SKIP_FRAMES;
    localparam int FRM_W   = (FRM_MAX > 1) ? $clog2(FRM_MAX) : 1;

    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic              w_rise;
    logic              w_fall;
    logic              w_wrap;
    logic              w_lft_load;
    logic              w_rht_load;
    logic              w_tx_load;
    logic [SMPL_W-1:0] w_tx_load_val;
    logic [SMPL_W-1:0] w_tx_q;
    logic [SMPL_W-1:0] w_rx_q;
    logic              w_rx_bit;
    logic              w_sdin_nxt;
    logic [SMPL_W-1:0] r_lft_buf;
    logic              w_unused_tx;

    codec_state_t      r_state;
    codec_state_t      w_state_nxt;
    logic [FRM_W-1:0]  r_frm_cnt;
    logic [FRM_W-1:0]  w_frm_cnt_nxt;

    // ------------------------------------------------------------------
    // Frame counter and clock outputs. The clock outputs are registered
    // from the next count, so each output equals its cnt bit in the same
    // cycle. As a result, SCLK rises at the edge that ends cnt[4:0]==15.
    // ------------------------------------------------------------------
    assign w_cnt_nxt = r_cnt + CNT_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            MCLK  <= 1'b0;
            SCLK  <= 1'b0;
            LRCLK <= 1'b0;
        end else begin
            r_cnt <= w_cnt_nxt;
            MCLK  <= w_cnt_nxt[1];
            SCLK  <= w_cnt_nxt[4];
            LRCLK <= w_cnt_nxt[9];
        end
    end

    assign w_rise     = (r_cnt[4:0] == RISE_PH);
    assign w_fall     = (r_cnt[4:0] == FALL_PH);
    assign w_lft_load = (r_cnt == LFT_LOAD);
    assign w_rht_load = (r_cnt == RHT_LOAD);
    assign w_wrap     = w_lft_load;

    // ------------------------------------------------------------------
    // Serial data routing
    // ------------------------------------------------------------------
`ifdef CODEC_LOOPBACK_EN
    logic w_unused_sdout;
    assign w_unused_sdout = SDout;
    assign w_rx_bit       = w_tx_q[SMPL_W-1];
    assign w_sdin_nxt     = 1'b0;
`else
    assign w_rx_bit       = SDout;
    assign w_sdin_nxt     = w_tx_q[SMPL_W-1];
`endif

    // ------------------------------------------------------------------
    // TX: load at the start of each half, then shift on each SCLK fall
    // ------------------------------------------------------------------
    assign w_tx_load     = w_lft_load | w_rht_load;
    assign w_tx_load_val = w_lft_load ? lft_in : rht_in;

    codec_shreg #(.WIDTH(SMPL_W)) u_tx_shreg (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (w_tx_load),
        .load_val (w_tx_load_val),
        .shift_en (w_fall),
        .ser_in   (1'b0),
        .q        (w_tx_q)
    );

    // Only the MSB leaves the shifter
    assign w_unused_tx = ^w_tx_q[SMPL_W-2:0];

    // ------------------------------------------------------------------
    // RX: capture on every SCLK rise
    // ------------------------------------------------------------------
    codec_shreg #(.WIDTH(SMPL_W)) u_rx_shreg (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (1'b0),
        .load_val ({SMPL_W{1'b0}}),
        .shift_en (w_rise),
        .ser_in   (w_rx_bit),
        .q        (w_rx_q)
    );

    // ------------------------------------------------------------------
    // Sample outputs. The left word is parked until the right word
    // completes, so both channels update together with valid.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lft_buf <= '0;
            lft_out   <= '0;
            rht_out   <= '0;
            valid     <= 1'b0;
            SDin      <= 1'b0;
        end else begin
            SDin  <= w_sdin_nxt;
            valid <= 1'b0;
            if (r_cnt == LFT_DONE) begin
                r_lft_buf <= w_rx_q;
            end
            if (r_cnt == FRAME_DONE) begin
                lft_out <= r_lft_buf;
                rht_out <= w_rx_q;
                valid   <= (r_state == RUN);
            end
        end
    end

    // ------------------------------------------------------------------
    // Reset FSM: hold the CODEC in reset, then let it warm up, then run
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= INIT;
            r_frm_cnt <= '0;
            RSTn      <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_frm_cnt <= w_frm_cnt_nxt;
            RSTn      <= (w_state_nxt != INIT);
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_frm_cnt_nxt = r_frm_cnt;
        case (r_state)
            INIT: begin
                if (w_wrap) begin
                    if (r_frm_cnt == FRM_W'(INIT_FRAMES - 1)) begin
                        w_state_nxt   = WARM;
                        w_frm_cnt_nxt = '0;
                    end else begin
                        w_frm_cnt_nxt = r_frm_cnt + FRM_W'(1);
                    end
                end
            end
            WARM: begin
                if (w_wrap) begin
                    if (r_frm_cnt == FRM_W'(SKIP_FRAMES - 1)) begin
                        w_state_nxt   = RUN;
                        w_frm_cnt_nxt = '0;
                    end else begin
                        w_frm_cnt_nxt = r_frm_cnt + FRM_W'(1);
                    end
                end
            end
            RUN: begin
                w_state_nxt = RUN;
            end
            default: begin
                w_state_nxt   = INIT;
                w_frm_cnt_nxt = '0;
            end
        endcase
    end

endmodule : codec_intf
`default_nettype wire
